// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared types and constants for the unified memory port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } arb_state_e;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_CPU  = 2'b01;
  localparam logic [1:0] GRANT_DBG  = 2'b10;

  localparam int MAX_MEM_LAT = 15;
  localparam int CNT_W       = $clog2(MAX_MEM_LAT + 1);

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/mem_arb_pick.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pick
// Description : Combinational winner select between CPU and debug requesters.
//               MEM_PORT_ARBITER_RR_EN selects round-robin, otherwise Dbg > CPU.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic       cpu_req,
  input  logic       dbg_req,
  input  logic       last_winner_dbg,
  output logic [1:0] grant
);

`ifdef MEM_PORT_ARBITER_RR_EN
  // On contention the port that did not win last time goes first.
  always_comb begin
    grant = GRANT_NONE;
    if (cpu_req && dbg_req) begin
      grant = last_winner_dbg ? GRANT_CPU : GRANT_DBG;
    end else if (dbg_req) begin
      grant = GRANT_DBG;
    end else if (cpu_req) begin
      grant = GRANT_CPU;
    end
  end
`else
  logic unused_last_winner;
  assign unused_last_winner = last_winner_dbg;

  always_comb begin
    grant = GRANT_NONE;
    if (dbg_req) begin
      grant = GRANT_DBG;
    end else if (cpu_req) begin
      grant = GRANT_CPU;
    end
  end
`endif

endmodule : mem_arb_pick
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one memory port between the CPU and a debug loader,
//               sequencing each access over MEM_LAT cycles.
//               Build option: MEM_PORT_ARBITER_RR_EN (round-robin arbitration).
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LAT = 1,
  parameter int ADDR_W  = 32
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Cpu_req,
  input  logic [ADDR_W-1:0] Cpu_addr,
  input  logic [31:0]       Cpu_wdata,
  input  logic [3:0]        Cpu_byte_write,
  output logic              Cpu_ack,
  output logic [31:0]       Cpu_rdata,
  input  logic              Dbg_req,
  input  logic [ADDR_W-1:0] Dbg_addr,
  input  logic [31:0]       Dbg_wdata,
  input  logic [3:0]        Dbg_byte_write,
  output logic              Dbg_ack,
  output logic [31:0]       Dbg_rdata,
  output logic [ADDR_W-1:0] Mem_addr,
  output logic [31:0]       Mem_wdata,
  output logic [3:0]        Mem_byte_write,
  input  logic [31:0]       Mem_rdata,
  output logic [1:0]        Grant,
  output logic              Busy
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);

  arb_state_e        state_q, state_d;
  logic [1:0]        grant_q, grant_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       cpu_rdata_q, cpu_rdata_d;
  logic [31:0]       dbg_rdata_q, dbg_rdata_d;
  logic              last_dbg_q, last_dbg_d;
  logic [1:0]        pick_grant;
  logic              done;

  mem_arb_pick u_pick (
    .cpu_req         (Cpu_req),
    .dbg_req         (Dbg_req),
    .last_winner_dbg (last_dbg_q),
    .grant           (pick_grant)
  );

  assign done = (state_q == ACCESS) && (cnt_q == '0);

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = 4'b0000;  // byte enables live for the first ACCESS cycle only
    cpu_rdata_d = cpu_rdata_q;
    dbg_rdata_d = dbg_rdata_q;
    last_dbg_d  = last_dbg_q;
    case (state_q)
      IDLE: begin
        if (pick_grant != GRANT_NONE) begin
          state_d = ACCESS;
          grant_d = pick_grant;
          cnt_d   = CNT_INIT;
          if (pick_grant == GRANT_DBG) begin
            addr_d  = Dbg_addr;
            wdata_d = Dbg_wdata;
            be_d    = Dbg_byte_write;
          end else begin
            addr_d  = Cpu_addr;
            wdata_d = Cpu_wdata;
            be_d    = Cpu_byte_write;
          end
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          state_d    = IDLE;
          grant_d    = GRANT_NONE;
          last_dbg_d = (grant_q == GRANT_DBG);
          if (grant_q == GRANT_DBG) begin
            dbg_rdata_d = Mem_rdata;
          end else begin
            cpu_rdata_d = Mem_rdata;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = GRANT_NONE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q     <= IDLE;
      grant_q     <= GRANT_NONE;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
      last_dbg_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      cpu_rdata_q <= cpu_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
      last_dbg_q  <= last_dbg_d;
    end
  end

  assign Cpu_ack        = done && (grant_q == GRANT_CPU);
  assign Dbg_ack        = done && (grant_q == GRANT_DBG);
  assign Cpu_rdata      = cpu_rdata_q;
  assign Dbg_rdata      = dbg_rdata_q;
  assign Mem_addr       = addr_q;
  assign Mem_wdata      = wdata_q;
  assign Mem_byte_write = be_q;
  assign Grant          = grant_q;
  assign Busy           = (state_q == ACCESS);

endmodule : mem_port_arbiter
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Randomized self-checking bench for mem_port_arbiter against an
//               access-slot reference model. Honours MEM_PORT_ARBITER_RR_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  localparam int LAT      = 3;
  localparam int NCYC     = 2000;
  localparam int SAT_END  = 200;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_drv   [2];
  logic [31:0] addr_drv  [2];
  logic [31:0] wdata_drv [2];
  logic [3:0]  be_drv    [2];

  logic        cpu_ack, dbg_ack, busy;
  logic [31:0] cpu_rdata, dbg_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic [1:0]  grant;

  logic [31:0] dut_mem [16];
  logic [31:0] ref_mem [16];

  // Reference model: owner 0 = none, 1 = CPU, 2 = Dbg; elapsed counts ACCESS cycles.
  int          m_owner, m_elapsed;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_be;
  logic        m_last_dbg;
  logic [31:0] m_rdata [2];

  int n_checks = 0;
  int n_errors = 0;
  int cyc_now  = 0;
  int sat_acks [2];

  always #5 clk = ~clk;

  mem_port_arbiter #(.MEM_LAT(LAT), .ADDR_W(32)) dut (
    .Clk            (clk),
    .Rst            (rst),
    .Cpu_req        (req_drv[0]),
    .Cpu_addr       (addr_drv[0]),
    .Cpu_wdata      (wdata_drv[0]),
    .Cpu_byte_write (be_drv[0]),
    .Cpu_ack        (cpu_ack),
    .Cpu_rdata      (cpu_rdata),
    .Dbg_req        (req_drv[1]),
    .Dbg_addr       (addr_drv[1]),
    .Dbg_wdata      (wdata_drv[1]),
    .Dbg_byte_write (be_drv[1]),
    .Dbg_ack        (dbg_ack),
    .Dbg_rdata      (dbg_rdata),
    .Mem_addr       (mem_addr),
    .Mem_wdata      (mem_wdata),
    .Mem_byte_write (mem_be),
    .Mem_rdata      (mem_rdata),
    .Grant          (grant),
    .Busy           (busy)
  );

  assign mem_rdata = dut_mem[mem_addr[5:2]];

  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (mem_be[b]) dut_mem[mem_addr[5:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc_now);
    end
  endtask

  task automatic model_reset();
    m_owner    = 0;
    m_elapsed  = 0;
    m_addr     = '0;
    m_wdata    = '0;
    m_be       = '0;
    m_last_dbg = 1'b1;
    m_rdata[0] = '0;
    m_rdata[1] = '0;
  endtask

  function automatic logic exp_ack(input int p);
    return (m_owner == p + 1) && (m_elapsed == LAT - 1);
  endfunction

  task automatic model_step();
    logic [31:0] rd;
    int          win;
    rd = '0;
    // Memory effects happen even in a reset cycle; read precedes the write.
    if (m_owner != 0) begin
      if (m_elapsed == LAT - 1) rd = ref_mem[m_addr[5:2]];
      if (m_elapsed == 0) begin
        for (int b = 0; b < 4; b++)
          if (m_be[b]) ref_mem[m_addr[5:2]][8*b +: 8] = m_wdata[8*b +: 8];
      end
    end
    if (rst) begin
      model_reset();
    end else if (m_owner != 0) begin
      if (m_elapsed == LAT - 1) begin
        m_rdata[m_owner - 1] = rd;
        m_last_dbg           = (m_owner == 2);
        m_owner              = 0;
      end else begin
        m_elapsed++;
      end
    end else if (req_drv[0] || req_drv[1]) begin
`ifdef MEM_PORT_ARBITER_RR_EN
      if (req_drv[0] && req_drv[1]) win = m_last_dbg ? 0 : 1;
      else                          win = req_drv[1] ? 1 : 0;
`else
      win = req_drv[1] ? 1 : 0;
`endif
      m_owner   = win + 1;
      m_elapsed = 0;
      m_addr    = addr_drv[win];
      m_wdata   = wdata_drv[win];
      m_be      = be_drv[win];
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      dut_mem[i] = $urandom;
      ref_mem[i] = dut_mem[i];
    end
    for (int p = 0; p < 2; p++) begin
      req_drv[p]   = 1'b0;
      addr_drv[p]  = '0;
      wdata_drv[p] = '0;
      be_drv[p]    = '0;
      sat_acks[p]  = 0;
    end
    model_reset();
    rst = 1'b1;
    @(posedge clk);

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      cyc_now = cyc;
      #1;
      check_value("busy",      {31'b0, busy},      {31'b0, m_owner != 0});
      check_value("grant",     {30'b0, grant},     (m_owner == 1) ? 32'd1 : (m_owner == 2) ? 32'd2 : 32'd0);
      check_value("mem_addr",  mem_addr,           m_addr);
      check_value("mem_wdata", mem_wdata,          m_wdata);
      check_value("mem_be",    {28'b0, mem_be},    (m_owner != 0 && m_elapsed == 0) ? {28'b0, m_be} : 32'd0);
      check_value("cpu_ack",   {31'b0, cpu_ack},   {31'b0, exp_ack(0)});
      check_value("dbg_ack",   {31'b0, dbg_ack},   {31'b0, exp_ack(1)});
      check_value("cpu_rdata", cpu_rdata,          m_rdata[0]);
      check_value("dbg_rdata", dbg_rdata,          m_rdata[1]);
      if (cyc < SAT_END) begin
        if (cpu_ack) sat_acks[0]++;
        if (dbg_ack) sat_acks[1]++;
      end

      // Reset pulse in the 2nd ACCESS cycle of a CPU access, occasionally.
      rst = (cyc == 0) ||
            (cyc >= SAT_END && m_owner == 1 && m_elapsed == 1 && $urandom_range(0, 5) == 0);

      for (int p = 0; p < 2; p++) begin
        if (exp_ack(p)) begin
          req_drv[p] = 1'b0;
        end else if (cyc >= SAT_END && m_owner == p + 1 && m_elapsed >= 1 &&
                     $urandom_range(0, 7) == 0) begin
          req_drv[p] = 1'b0;
        end
        if (cyc >= SAT_END && m_owner == p + 1 && $urandom_range(0, 2) == 0) begin
          addr_drv[p]  = $urandom;
          wdata_drv[p] = $urandom;
        end
        if (!req_drv[p] && m_owner != p + 1 &&
            (cyc < SAT_END || $urandom_range(0, 1) == 0)) begin
          req_drv[p]   = 1'b1;
          addr_drv[p]  = $urandom;
          wdata_drv[p] = $urandom;
          be_drv[p]    = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'b0000;
        end
      end

      model_step();
      @(posedge clk);
    end

    // With both ports requesting continuously after reset.
`ifdef MEM_PORT_ARBITER_RR_EN
    check_value("sat_alternate", {31'b0, (sat_acks[0] == sat_acks[1]) || (sat_acks[0] == sat_acks[1] + 1)}, 32'd1);
    check_value("sat_cpu_served", {31'b0, sat_acks[0] > 0}, 32'd1);
`else
    check_value("sat_cpu_starved", sat_acks[0], 32'd0);
    check_value("sat_dbg_served", {31'b0, sat_acks[1] > 0}, 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_mem_port_arbiter
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified Memory port of the multicycle CPU between two requesters: the CPU fetch/load/store path and a debug/program loader port.
- Sequences each access over a fixed read latency, returns read data and a one-cycle ack to the winning requester, and drives the Memory's address, write-data and byte-write inputs.
- Sits between the CPU's Mem_addr_in/Reg_data_shift/Mem_byte_write nets and the Memory instance. The CPU's controller holds its state until Cpu_ack.

Parameters:
- MEM_LAT, 1: cycles from address presented to valid Mem_rdata. Legal range 1..15.
- ADDR_W, 32: address width.

Ports:
- Clk  in  1  system clock; all state updates on rising edge
- Rst  in  1  synchronous, active-high reset
- Cpu_req  in  1  CPU access request, level
- Cpu_addr  in  ADDR_W  CPU byte address
- Cpu_wdata  in  32  CPU write data (already lane-shifted)
- Cpu_byte_write  in  4  CPU byte write enables; 0 means read
- Cpu_ack  out  1  one-cycle completion pulse to CPU
- Cpu_rdata  out  32  CPU read data
- Dbg_req  in  1  loader access request, level
- Dbg_addr  in  ADDR_W  loader byte address
- Dbg_wdata  in  32  loader write data
- Dbg_byte_write  in  4  loader byte write enables; 0 means read
- Dbg_ack  out  1  one-cycle completion pulse to loader
- Dbg_rdata  out  32  loader read data
- Mem_addr  out  ADDR_W  to Memory address
- Mem_wdata  out  32  to Memory write data
- Mem_byte_write  out  4  to Memory byte write enables
- Mem_rdata  in  32  from Memory read data
- Grant  out  2  one-hot owner: bit0 CPU, bit1 Dbg; 00 when idle
- Busy  out  1  high while in ACCESS

Behaviour:
- Reset values: state IDLE, Grant 00, Busy 0, both acks 0, Cpu_rdata 0, Dbg_rdata 0, Mem_addr 0, Mem_wdata 0, Mem_byte_write 0, latency counter 0, last_winner = Dbg.
- Reset is synchronous and active-high. It clock-synchronously overrides every other input.
- Requester protocol: hold req, addr, wdata and byte_write stable until ack. Ack is high for exactly one cycle.
- Each rdata is registered and holds until that port's next ack.
- FSM states: IDLE and ACCESS.
- IDLE:
  - If any req is high, pick a winner (see arbitration).
  - Next cycle: ACCESS, Grant set, counter = MEM_LAT-1, winner's signals latched into Mem_addr, Mem_wdata and Mem_byte_write.
- ACCESS:
  - Mem_addr and Mem_wdata are driven from the latch for the whole access.
  - Mem_byte_write equals the latched value in the first ACCESS cycle only, and is 0 afterwards, so a write commits exactly once.
  - Counter decrements each cycle.
  - When counter==0: pulse the winner's ack, capture Mem_rdata into the winner's rdata (captured on writes too), set last_winner, and go to IDLE next cycle.
- Latency: req high in IDLE cycle N gives ack in cycle N+MEM_LAT.
- Back-to-back accesses are separated by exactly one IDLE cycle, so peak throughput is one access per MEM_LAT+1 cycles.
- Arbitration (default build): fixed priority, Dbg over CPU.
- Req deasserted mid-ACCESS: the access still completes and the ack still pulses. The loser's req is unaffected and is served next.
- Changes to the winner's inputs during ACCESS are ignored because the values are latched.
- Rst mid-ACCESS: abort with no ack. A write issued in the first ACCESS cycle stays committed.
- The Mem_addr width is ADDR_W. No address alignment is checked here.

Optional Feature:
- Macro: MEM_PORT_ARBITER_RR_EN.
- Defined: round-robin arbitration. On a simultaneous request the port that is not last_winner wins. A lone requester always wins. This guarantees a waiting port is served within one competing access.
- Undefined: fixed priority Dbg > CPU. last_winner is still tracked, but it does not affect selection.

Decomposition:
- Package mem_arb_pkg holds:
  - state enum {IDLE, ACCESS}
  - grant constants GRANT_NONE=2'b00, GRANT_CPU=2'b01, GRANT_DBG=2'b10
  - MAX_MEM_LAT=15
- One sub-module, mem_arb_pick: combinational winner select from (Cpu_req, Dbg_req, last_winner), containing the macro-dependent policy.

Test Plan:
- MEM_LAT=1; Cpu_req, addr 0x10, byte_write 0, Mem_rdata model returns 0xDEADBEEF -> Cpu_ack one cycle after req, Cpu_rdata=0xDEADBEEF, Grant=01 during ACCESS.
- MEM_LAT=3; Dbg write addr 0x40, wdata 0x12345678, byte_write 4'b1111 -> Mem_byte_write=1111 for exactly one cycle, Dbg_ack 3 cycles after req, Busy high for 3 cycles.
- Both reqs held continuously, MEM_LAT=1, macro undefined -> Dbg acked on every grant, CPU never acked. Macro defined -> acks alternate, CPU first after reset.
- Rst pulsed in 2nd ACCESS cycle (MEM_LAT=3) of a CPU read -> no Cpu_ack, all outputs at reset values the next cycle, FSM in IDLE.
- CPU drops req in the middle of ACCESS -> Cpu_ack still pulses. Dbg_req pending from the same cycle -> Dbg access starts after one IDLE cycle.
- MEM_LAT=2, CPU changes Cpu_addr during ACCESS -> Mem_addr stays at the latched value until ack.
